// File: rtl/mux2_stim_driver_if.sv
// Connection between the stimulus driver and the 2:1 mux under test.
// The driver owns i0/i1/sel; the mux (or its model) returns y.
interface mux2_stim_driver_if;
    logic i0;
    logic i1;
    logic sel;
    logic y;

    modport master (output i0, output i1, output sel, input y);
    modport slave  (input i0, input i1, input sel, output y);
endinterface

// File: rtl/mux2_stim_driver.sv
// Stimulus generator and self-checker for a 2:1 mux: drives exhaustive or LFSR vectors,
// compares y against sel?i1:i0 after DUT_LAT cycles, counts errors and records the first failure.
module mux2_stim_driver #(
    parameter int          NUM_VECTORS = 64,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          DUT_LAT     = 0,
    parameter int          ERR_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    mux2_stim_driver_if.master    mux,
    output logic                  busy,
    output logic                  done,
    output logic [ERR_W-1:0]      err_cnt,
    output logic [15:0]           first_err_idx,
    output logic [2:0]            first_err_vec
);
    typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] idx;
        logic [2:0]  vec;
        logic        exp;
    } chk_t;

    localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
    localparam logic [1:0]  LAST_DRAIN = 2'(DUT_LAT - 1);

    state_t           state_q, state_d;
    logic [15:0]      k_q, k_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic             mode_q, mode_d;
    logic [2:0]       vec_q, vec_d;
    logic [1:0]       drain_q, drain_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [15:0]      fidx_q, fidx_d;
    logic [2:0]       fvec_q, fvec_d;
    logic [15:0]      lfsr_step;
    chk_t             cur;
    chk_t             chk;
    logic             mismatch;

    // Fibonacci LFSR, taps 16,14,13,11, shifting towards the msb.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    assign lfsr_step = lfsr_next(lfsr_q);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        lfsr_d  = lfsr_q;
        mode_d  = mode_q;
        vec_d   = vec_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                vec_d = 3'b000;
                if (start) begin
                    mode_d  = mode;
                    k_d     = 16'd0;
                    lfsr_d  = LFSR_SEED;
                    vec_d   = mode ? LFSR_SEED[2:0] : 3'b000;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (k_q == LAST_IDX) begin
                    vec_d   = 3'b000;
                    drain_d = 2'd0;
                    state_d = (DUT_LAT == 0) ? DONE : DRAIN;
                end else begin
                    k_d = k_q + 16'd1;
                    if (mode_q) begin
                        lfsr_d = lfsr_step;
                        vec_d  = lfsr_step[2:0];
                    end else begin
                        vec_d = k_d[2:0];
                    end
                end
            end
            DRAIN: begin
                vec_d   = 3'b000;
                drain_d = drain_q + 2'd1;
                if (drain_q == LAST_DRAIN) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                vec_d   = 3'b000;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cur = {state_q == DRIVE, k_q, vec_q, vec_q[2] ? vec_q[1] : vec_q[0]};
    end

    // The check record travels DUT_LAT stages so it lines up with the returning y.
    generate
        if (DUT_LAT == 0) begin : g_no_pipe
            assign chk = cur;
        end else begin : g_pipe
            chk_t pipe_q [DUT_LAT];
            chk_t pipe_d [DUT_LAT];

            always_comb begin
                pipe_d[0] = cur;
                for (int i = 1; i < DUT_LAT; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DUT_LAT; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign chk = pipe_q[DUT_LAT-1];
        end
    endgenerate

    // A zero count doubles as "no failure captured yet", since it saturates rather than wraps.
    always_comb begin
        err_d    = err_q;
        fidx_d   = fidx_q;
        fvec_d   = fvec_q;
        mismatch = chk.valid && (mux.y !== chk.exp);
        if (state_q == IDLE && start) begin
            err_d  = '0;
            fidx_d = 16'd0;
            fvec_d = 3'b000;
        end else if (mismatch) begin
            if (err_q != '1) begin
                err_d = err_q + ERR_W'(1);
            end
            if (err_q == '0) begin
                fidx_d = chk.idx;
                fvec_d = chk.vec;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= 16'd0;
            lfsr_q  <= LFSR_SEED;
            mode_q  <= 1'b0;
            vec_q   <= 3'b000;
            drain_q <= 2'd0;
            err_q   <= '0;
            fidx_q  <= 16'd0;
            fvec_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            lfsr_q  <= lfsr_d;
            mode_q  <= mode_d;
            vec_q   <= vec_d;
            drain_q <= drain_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fvec_q  <= fvec_d;
        end
    end

    assign mux.sel       = vec_q[2];
    assign mux.i1        = vec_q[1];
    assign mux.i0        = vec_q[0];
    assign busy          = (state_q == DRIVE) || (state_q == DRAIN);
    assign done          = (state_q == DONE);
    assign err_cnt       = err_q;
    assign first_err_idx = fidx_q;
    assign first_err_vec = fvec_q;
endmodule
